// File: rtl/share_decoder_if.sv
// Handshake bundle for share_decoder: share-pair input side and decoded-word output side.
interface share_decoder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] s0;
   logic [WIDTH-1:0] s1;
   logic [WIDTH-1:0] rnd;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] d;
   logic [15:0]      dec_count;

   modport master (
      output in_valid, s0, s1, rnd, out_ready,
      input  in_ready, out_valid, d, dec_count
   );

   modport slave (
      input  in_valid, s0, s1, rnd, out_ready,
      output in_ready, out_valid, d, dec_count
   );
endinterface

// File: rtl/share_decoder.sv
// Two-share unmasking decoder: shares are refreshed with rnd into registers and only
// those registered shares are recombined, feeding a credit-controlled output FIFO.
module share_decoder #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input logic            clk,
   input logic            rst,
   share_decoder_if.slave bus
);
   localparam int              PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int              CW        = $clog2(DEPTH + 1);
   localparam logic [PW-1:0]   PTR_LAST  = PW'(DEPTH - 1);
   localparam logic [CW:0]     DEPTH_OCC = (CW + 1)'(DEPTH);

   logic [WIDTH-1:0] r0_r;
   logic [WIDTH-1:0] r1_r;
   logic             v1_r;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    cnt_r;
   logic [15:0]      dec_count_r;

   logic [CW:0]      occ_s;
   logic             in_ready_s;
   logic             out_valid_s;
   logic             in_hs_s;
   logic             push_s;
   logic             pop_s;
   logic [WIDTH-1:0] comb_s;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      logic [PW-1:0] nxt;
      if (ptr == PTR_LAST) begin
         nxt = {PW{1'b0}};
      end else begin
         nxt = ptr + PW'(1);
      end
      return nxt;
   endfunction

   // Credit and handshake decode; a word in the refresh stage already holds a FIFO slot
   always_comb begin
      occ_s       = {1'b0, cnt_r} + {{CW{1'b0}}, v1_r};
      in_ready_s  = (occ_s < DEPTH_OCC);
      out_valid_s = (cnt_r != {CW{1'b0}});
      in_hs_s     = bus.in_valid && in_ready_s;
      push_s      = v1_r;
      pop_s       = out_valid_s && bus.out_ready;
      comb_s      = r0_r ^ r1_r;
   end

   // Refresh stage: both shares masked with the same fresh rnd
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r0_r <= {WIDTH{1'b0}};
         r1_r <= {WIDTH{1'b0}};
         v1_r <= 1'b0;
      end else if (in_hs_s) begin
         r0_r <= bus.s0 ^ bus.rnd;
         r1_r <= bus.s1 ^ bus.rnd;
         v1_r <= 1'b1;
      end else begin
         v1_r <= 1'b0;
      end
   end

   // Output FIFO storage, circular pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         cnt_r    <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= comb_s;
            wr_ptr_r        <= ptr_inc(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_s, pop_s})
            2'b10:   cnt_r <= cnt_r + CW'(1);
            2'b01:   cnt_r <= cnt_r - CW'(1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   // Completed output handshakes, wrapping at 16 bits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dec_count_r <= 16'd0;
      end else if (pop_s) begin
         dec_count_r <= dec_count_r + 16'd1;
      end else begin
         dec_count_r <= dec_count_r;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.d         = mem_r[rd_ptr_r];
   assign bus.dec_count = dec_count_r;
endmodule

// File: tb/tb_share_decoder.sv
// Self-checking bench for share_decoder: queue-based reference model compared every
// cycle, plus directed literal checks and a wrap run on a deeper instance.
module tb_share_decoder;
   localparam int WIDTH      = 8;
   localparam int DEPTH      = 2;
   localparam int WRAP_DEPTH = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   share_decoder_if #(.WIDTH(WIDTH)) bus ();
   share_decoder_if #(.WIDTH(WIDTH)) bus_w ();

   share_decoder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   share_decoder #(.WIDTH(WIDTH), .DEPTH(WRAP_DEPTH)) u_dut_w (
      .clk(clk), .rst(rst), .bus(bus_w)
   );

   always #5 clk = ~clk;

   // Reference model: words waiting in the refresh stage and the FIFO as a queue
   logic [WIDTH-1:0] fifo_m [$];
   logic             stage_v_m = 1'b0;
   logic [WIDTH-1:0] stage_w_m = '0;
   logic [15:0]      dec_m = 16'd0;
   logic             acc_m;
   logic             pop_m;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic model_ready();
      return (fifo_m.size() + (stage_v_m ? 1 : 0)) < DEPTH;
   endfunction

   // Inputs only change at negedge+1, so at a negedge they still show what the last posedge saw
   always @(negedge clk) begin
      if (rst) begin
         fifo_m.delete();
         stage_v_m = 1'b0;
         dec_m     = 16'd0;
      end else begin
         acc_m = bus.in_valid && model_ready();
         pop_m = (fifo_m.size() != 0) && bus.out_ready;
         if (pop_m) begin
            void'(fifo_m.pop_front());
            dec_m = dec_m + 16'd1;
         end
         if (stage_v_m) fifo_m.push_back(stage_w_m);
         stage_v_m = acc_m;
         stage_w_m = bus.s0 ^ bus.s1;
      end
      check("in_ready", 32'(bus.in_ready), 32'(model_ready()));
      check("out_valid", 32'(bus.out_valid), 32'(fifo_m.size() != 0));
      check("dec_count", 32'(bus.dec_count), 32'(dec_m));
      if (fifo_m.size() != 0) check("d", 32'(bus.d), 32'(fifo_m[0]));
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Caller holds out_ready = 1 and an idle block
   task automatic send_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] exp);
      check("send_ready", 32'(bus.in_ready), 32'h1);
      bus.in_valid = 1'b1;
      bus.s0 = a;
      bus.s1 = b;
      bus.rnd = r;
      step();
      bus.in_valid = 1'b0;
      bus.rnd = WIDTH'($urandom);
      check("early_valid", 32'(bus.out_valid), 32'h0);
      step();
      check("word_valid", 32'(bus.out_valid), 32'h1);
      check("word_d", 32'(bus.d), 32'(exp));
      check("model_word", (fifo_m.size() != 0) ? 32'(fifo_m[0]) : 32'hDEAD, 32'(exp));
      step();
   endtask

   logic             hs;
   logic             acc;
   logic [WIDTH-1:0] w;
   logic [WIDTH-1:0] got_w [3];
   logic [WIDTH-1:0] rnd_tab [3];
   int               n;
   int               got;
   int               sent;

   initial begin
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.s0 = '0; bus.s1 = '0; bus.rnd = '0;
      bus_w.in_valid = 1'b0; bus_w.out_ready = 1'b0;
      bus_w.s0 = '0; bus_w.s1 = '0; bus_w.rnd = '0;
      rnd_tab[0] = 8'h00; rnd_tab[1] = 8'h5A; rnd_tab[2] = 8'hFF;

      // Reset values
      step();
      step();
      check("rst_in_ready", 32'(bus.in_ready), 32'h1);
      check("rst_out_valid", 32'(bus.out_valid), 32'h0);
      check("rst_d", 32'(bus.d), 32'h0);
      check("rst_dec", 32'(bus.dec_count), 32'h0);
      check("rst_w_dec", 32'(bus_w.dec_count), 32'h0);
      rst = 1'b0;

      // Single word, then randomness independence
      bus.out_ready = 1'b1;
      step();
      send_one(8'h3C, 8'h5A, 8'hFF, 8'h66);
      check("one_dec", 32'(bus.dec_count), 32'h1);
      check("model_dec", 32'(dec_m), 32'h1);
      foreach (rnd_tab[i]) send_one(8'hA5, 8'h0F, rnd_tab[i], 8'hAA);
      check("rnd_dec", 32'(bus.dec_count), 32'h4);

      // Backpressure: only DEPTH pairs enter while out_ready is low
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.s0 = 8'h11; bus.s1 = 8'h00; bus.rnd = WIDTH'($urandom);
      step();
      check("bp_ready_1", 32'(bus.in_ready), 32'h1);
      bus.s0 = 8'h22; bus.rnd = WIDTH'($urandom);
      step();
      check("bp_ready_low", 32'(bus.in_ready), 32'h0);
      bus.s0 = 8'h33; bus.rnd = WIDTH'($urandom);
      repeat (3) begin
         step();
         check("bp_hold_ready", 32'(bus.in_ready), 32'h0);
         check("bp_hold_d", 32'(bus.d), 32'h11);
      end
      bus.out_ready = 1'b1;
      n = 0;
      for (int c = 0; c < 20 && n < 3; c++) begin
         hs  = bus.out_valid && bus.out_ready;
         w   = bus.d;
         acc = bus.in_valid && bus.in_ready;
         step();
         if (hs) begin
            got_w[n] = w;
            n++;
         end
         if (acc) bus.in_valid = 1'b0;
      end
      check("bp_count", 32'(n), 32'd3);
      check("bp_out0", 32'(got_w[0]), 32'h11);
      check("bp_out1", 32'(got_w[1]), 32'h22);
      check("bp_out2", 32'(got_w[2]), 32'h33);
      check("bp_dec", 32'(bus.dec_count), 32'd7);

      // Streaming random pairs
      sent = 0; got = 0;
      bus.in_valid = 1'b1;
      bus.s0 = WIDTH'($urandom); bus.s1 = WIDTH'($urandom); bus.rnd = WIDTH'($urandom);
      for (int c = 0; c < 400 && got < 100; c++) begin
         hs  = bus.out_valid && bus.out_ready;
         acc = bus.in_valid && bus.in_ready;
         step();
         if (hs) got++;
         if (acc) begin
            sent++;
            if (sent == 100) begin
               bus.in_valid = 1'b0;
            end else begin
               bus.s0 = WIDTH'($urandom); bus.s1 = WIDTH'($urandom); bus.rnd = WIDTH'($urandom);
            end
         end
      end
      check("stream_sent", 32'(sent), 32'd100);
      check("stream_got", 32'(got), 32'd100);
      check("stream_dec", 32'(bus.dec_count), 32'd107);

      // Reset mid-operation with one word in the FIFO and one in the refresh stage
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.s0 = WIDTH'($urandom); bus.s1 = WIDTH'($urandom);
      step();
      bus.s0 = WIDTH'($urandom); bus.s1 = WIDTH'($urandom);
      @(posedge clk);
      #2;
      check("pre_rst_valid", 32'(bus.out_valid), 32'h1);
      check("pre_rst_ready", 32'(bus.in_ready), 32'h0);
      rst = 1'b1;
      bus.in_valid = 1'b0;
      #1;
      check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
      check("mid_rst_ready", 32'(bus.in_ready), 32'h1);
      check("mid_rst_dec", 32'(bus.dec_count), 32'h0);
      check("mid_rst_d", 32'(bus.d), 32'h0);
      step();
      rst = 1'b0;
      bus.out_ready = 1'b1;
      repeat (5) step();
      check("post_rst_valid", 32'(bus.out_valid), 32'h0);
      check("post_rst_dec", 32'(bus.dec_count), 32'h0);

      // Counter wrap on the deeper instance, which sustains one word per cycle
      bus_w.out_ready = 1'b1;
      bus_w.in_valid = 1'b1;
      n = 0;
      for (int c = 0; c < 70000 && n < 65537; c++) begin
         hs = bus_w.out_valid && bus_w.out_ready;
         step();
         if (hs) begin
            n++;
            if (n == 65535) check("wrap_ffff", 32'(bus_w.dec_count), 32'h0000FFFF);
            else if (n == 65536) check("wrap_0000", 32'(bus_w.dec_count), 32'h0);
            else if (n == 65537) check("wrap_0001", 32'(bus_w.dec_count), 32'h1);
         end
         bus_w.s0 = WIDTH'($urandom);
         bus_w.s1 = WIDTH'($urandom);
         bus_w.rnd = WIDTH'($urandom);
      end
      bus_w.in_valid = 1'b0;
      check("wrap_count", 32'(n), 32'd65537);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
